// File: rtl/seq_tx_if.sv
// Command and serial-stream signals of the pattern transmitter.
// master drives the pattern request; slave is the transmitter itself.
interface seq_tx_if #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4,
  parameter int GAPW  = 4,
  parameter int REPW  = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LENW-1:0]  len;
  logic [GAPW-1:0]  gap;
  logic [REPW-1:0]  repeat_n;
  logic             hold;
  logic             data;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, gap, repeat_n, hold,
    input  data, data_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, gap, repeat_n, hold,
    output data, data_valid, busy, done
  );
endinterface

// File: rtl/seq_tx.sv
// Serial pattern transmitter: low len bits MSB-first, optional gaps and repeats; first bit one cycle after start.
// hold stalls bit and gap progress on the edge that samples it; all outputs registered.
module seq_tx #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4,
  parameter int GAPW  = 4,
  parameter int REPW  = 4
) (
  input logic    clk,
  input logic    rst,
  seq_tx_if.slave bus
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LENW-1:0] LEN_MAX = LENW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDXW-1:0]  lenm1_q, lenm1_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [GAPW-1:0]  gap_q, gap_d;
  logic [GAPW-1:0]  gcnt_q, gcnt_d;
  logic [REPW-1:0]  frm_q, frm_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LENW-1:0]  len_eff;

  // Out-of-range lengths (0 or above WIDTH) send the whole pattern.
  assign len_eff = ((bus.len == '0) || (bus.len > LEN_MAX)) ? LEN_MAX : bus.len;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    lenm1_d = lenm1_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    frm_d   = frm_q;
    data_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          lenm1_d = IDXW'(len_eff - 1'b1);
          idx_d   = IDXW'(len_eff - 1'b1);
          gap_d   = bus.gap;
          frm_d   = bus.repeat_n;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.hold) begin
          data_d  = pat_q[idx_q];
          valid_d = 1'b1;
          if ((idx_q == '0) && (frm_q == '0)) begin
            state_d = DONE;
          end else begin
            if (idx_q == '0) begin
              frm_d = frm_q - 1'b1;
              idx_d = lenm1_q;
            end else begin
              idx_d = idx_q - 1'b1;
            end
            // Gaps also separate the last bit of one frame from the first of the next.
            if (gap_q != '0) begin
              gcnt_d  = gap_q;
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (!bus.hold) begin
          gcnt_d = gcnt_q - 1'b1;
          if (gcnt_q == GAPW'(1)) state_d = SEND;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      lenm1_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      frm_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      lenm1_q <= lenm1_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      frm_q   <= frm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: vector table plus hand-written reset and back-to-back sequences.
module tb_seq_tx;
  logic clk;
  logic rst;

  seq_tx_if bus ();

  seq_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] gap;
    logic [3:0] rep;
    int         hold_at;
    int         hold_len;
    int         restart;
    int         exp_bits;
    int         exp_done;
    bit         chk_match;
  } vec_t;

  vec_t vecs[9];
  bit   sb[$];
  int   n_chk;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference bit order: low effective-len bits, MSB first, rep+1 times.
  task automatic push_frame(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int eff;
    eff = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    for (int f = 0; f <= int'(r); f++)
      for (int i = eff - 1; i >= 0; i--)
        sb.push_back(p[i]);
  endtask

  task automatic run_vec(input vec_t v);
    int       done_at;
    int       nvalid;
    int       ndone;
    bit       matched;
    bit       expb;
    logic [3:0] det;
    done_at = -1;
    nvalid  = 0;
    ndone   = 0;
    matched = 1'b0;
    det     = 4'h0;
    push_frame(v.pattern, v.len, v.rep);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.pattern  = v.pattern;
    bus.len      = v.len;
    bus.gap      = v.gap;
    bus.repeat_n = v.rep;
    bus.hold     = 1'b0;
    @(posedge clk);
    for (int k = 0; k < v.exp_done + 6; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.data_valid) begin
        nvalid++;
        det = {det[2:0], bus.data};
        if (nvalid >= 4 && det == 4'b0110) matched = 1'b1;
        if (sb.size() == 0) begin
          check("extra valid bit", 1, 0);
        end else begin
          expb = sb.pop_front();
          check("serial bit", int'(bus.data), int'(expb));
        end
      end else begin
        check("data zero when not valid", int'(bus.data), 0);
      end
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) check("busy during first bit", int'(bus.busy), 1);
      if (done_at >= 0 && k == done_at + 1) begin
        check("busy low after done", int'(bus.busy), 0);
        check("done is one cycle", int'(bus.done), 0);
        break;
      end
      bus.hold = (k >= v.hold_at && k < v.hold_at + v.hold_len);
      if (v.restart != 0 && k == v.restart) begin
        bus.start    = 1'b1;
        bus.pattern  = ~v.pattern;
        bus.len      = 4'd1;
        bus.gap      = 4'd0;
        bus.repeat_n = 4'd0;
      end
      if (v.restart != 0 && k == v.restart + 1) bus.start = 1'b0;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    if (done_at < 0) check("done timeout", 0, 1);
    check("done cycle", done_at, v.exp_done);
    check("done pulse count", ndone, 1);
    check("valid bit count", nvalid, v.exp_bits);
    check("scoreboard drained", sb.size(), 0);
    if (v.chk_match) check("0110 detector match", int'(matched), 1);
    sb.delete();
  endtask

  initial begin
    int   nd;
    int   nv;
    int   m;
    bit   expb;
    n_chk  = 0;
    n_fail = 0;
    //           pattern len   gap   rep  hold_at len restart bits done match
    vecs[0] = '{8'h06, 4'd4,  4'd0,  4'd0, 0, 0, 0, 4,  5,  1'b0};
    vecs[1] = '{8'h06, 4'd4,  4'd2,  4'd0, 0, 0, 0, 4,  11, 1'b1};
    vecs[2] = '{8'hFF, 4'd0,  4'd0,  4'd0, 0, 0, 3, 8,  9,  1'b0};
    vecs[3] = '{8'hA5, 4'd8,  4'd1,  4'd1, 1, 3, 0, 16, 35, 1'b0};
    vecs[4] = '{8'h3C, 4'd9,  4'd0,  4'd2, 0, 0, 0, 24, 25, 1'b0};
    vecs[5] = '{8'h0B, 4'd3,  4'd3,  4'd1, 0, 0, 0, 6,  22, 1'b0};
    vecs[6] = '{8'h01, 4'd1,  4'd15, 4'd0, 0, 0, 0, 1,  2,  1'b0};
    vecs[7] = '{8'h06, 4'd4,  4'd0,  4'd0, 2, 2, 0, 4,  7,  1'b0};
    vecs[8] = '{8'h96, 4'd15, 4'd0,  4'd0, 0, 0, 0, 8,  9,  1'b1};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.pattern  = 8'h00;
    bus.len      = 4'd0;
    bus.gap      = 4'd0;
    bus.repeat_n = 4'd0;
    bus.hold     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", int'(bus.data), 0);
    check("reset data_valid", int'(bus.data_valid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset after the second bit aborts without a done pulse.
    push_frame(8'hA5, 4'd8, 4'd0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.pattern  = 8'hA5;
    bus.len      = 4'd8;
    bus.gap      = 4'd0;
    bus.repeat_n = 4'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      expb = sb.pop_front();
      check("pre-reset valid", int'(bus.data_valid), 1);
      check("pre-reset bit", int'(bus.data), int'(expb));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort data", int'(bus.data), 0);
    check("abort data_valid", int'(bus.data_valid), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    sb.delete();
    nd = 0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.data_valid) nv++;
    end
    check("no done after abort", nd, 0);
    check("no bits after abort", nv, 0);
    run_vec(vecs[0]);

    // start held high: frames spaced by the done cycle and one idle cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.pattern  = 8'h02;
    bus.len      = 4'd2;
    bus.gap      = 4'd0;
    bus.repeat_n = 4'd0;
    @(posedge clk);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      m = k % 4;
      check("b2b data_valid", int'(bus.data_valid), (m == 1 || m == 2) ? 1 : 0);
      check("b2b data", int'(bus.data), (m == 1) ? 1 : 0);
      check("b2b done", int'(bus.done), (m == 3) ? 1 : 0);
      check("b2b busy", int'(bus.busy), (m != 0) ? 1 : 0);
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b settles idle", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter that produces a one-bit stream with a `data_valid` qualifier. Valid bits may be non-contiguous, so the stream exercises gap-tolerant sequence detectors downstream. It loads a parallel pattern, emits its low `len` bits MSB-first, and can insert programmable idle gaps between bits, repeat the frame, and stall on a `hold` input. It sits on the stimulus/source side of the serial sequence-detection datapath.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LENW`, 4: width of `len`; must hold the value WIDTH.
- `GAPW`, 4: width of the gap count.
- `REPW`, 4: width of the repeat count.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to send; sampled only in IDLE.
- `pattern` input WIDTH: bits to send; latched on an accepted start.
- `len` input LENW: number of bits per frame, taken from `pattern[len-1:0]`. A value of 0 or greater than WIDTH is treated as WIDTH.
- `gap` input GAPW: idle cycles inserted after each bit, 0 to 2^GAPW-1. Latched on start.
- `repeat` input REPW: frame count is `repeat`+1. Latched on start.
- `hold` input 1: stall request; freezes bit and gap progress.
- `data` output 1: current serial bit. Meaningful only while `data_valid`=1; otherwise 0.
- `data_valid` output 1: `data` carries a valid bit this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the final bit of the final frame.

## Operation
- All outputs are registered. Reset values: `data`=0, `data_valid`=0, `busy`=0, `done`=0; the FSM is in IDLE.
- **IDLE:**
  - When `start`=1, latch `pattern`, the effective `len`, `gap` and `repeat`.
  - Set the bit index to len-1 and the frame counter to `repeat`, then go to SEND.
  - `start` is ignored in every state other than IDLE.
- **SEND**, with `hold`=0:
  - Drive `data`=`pattern[idx]` and `data_valid`=1 for one cycle.
  - Last bit of the frame (idx=0):
    - Frame counter at 0: go to DONE.
    - Otherwise: decrement the frame counter and reload idx=len-1.
  - Otherwise: decrement idx.
  - After any bit other than the final one, go to GAP if `gap`≠0; else stay in SEND.
- **SEND**, with `hold`=1: `data_valid`=0 and `data`=0; idx and the frame counter are unchanged.
- **GAP:**
  - Hold `data_valid`=0 for exactly `gap` cycles in which `hold`=0, then return to SEND.
  - A cycle with `hold`=1 does not count toward the gap.
- **Gap placement:** gaps follow every bit, including across frame boundaries. No gap follows the final bit.
- **DONE:** `done`=1 and `busy`=1 for one cycle, then IDLE. `hold` is ignored in this state.
- **Reset mid-stream:**
  - Aborts the transfer; no `done` is issued.
  - All outputs are 0 after the next edge.
  - Latched values need not be cleared.

## Timing
- `start`=1 in IDLE at edge t gives the first valid bit in cycle t+1 (one-cycle latency).
- With gap=0 and no hold, a frame of L bits occupies cycles t+1..t+L. `done` is in cycle t+N·L+1, where N = `repeat`+1, and `busy` falls in the following cycle.
- With gap=G and no hold, valid bits are spaced G+1 cycles apart. The total from the first bit to the last bit is (N·L−1)·(G+1)+1 cycles.
- Earliest next accepted start is the cycle after `done`, since IDLE is entered there.
- A change in `hold` takes effect in the same cycle: the registered outputs are updated on the edge that samples it.
- `pattern`, `len`, `gap` and `repeat` changing while `busy`=1 have no effect.

## Test plan
- **Basic frame:** `pattern`=8'h06, `len`=4, `gap`=0, `repeat`=0, `start` pulse → `data_valid`=1 for 4 consecutive cycles with `data` 0,1,1,0; `done` in cycle 5; `busy`=0 in cycle 6.
- **Gapped stream:** same pattern, `gap`=2 → valid bits 0,1,1,0 on cycles 1,4,7,10; `data_valid`=0 in between; `done` in cycle 11. A downstream 0110 detector with a valid qualifier must report a match.
- **Repeat plus hold:**
  - Setup: `pattern`=8'hA5, `len`=8, `repeat`=1, `gap`=1, `hold` high for 3 cycles during the first gap.
  - Required: 16 valid bits (A5 MSB-first, twice), with a gap between bit 8 and bit 9; the total is extended by exactly 3 cycles; `done` fires once.
- **Length clamp and ignored start:** `len`=0 with `pattern`=8'hFF → 8 valid bits. `start` re-asserted while `busy`=1 → no effect on the stream.
- **Reset mid-stream:** `rst` asserted after bit 2 → all outputs 0 on the next edge; no `done`. A new `start` after reset sends a full frame normally.
- **Back-to-back:** `start` held high continuously with `len`=2 and `gap`=0 → frames separated by exactly the DONE cycle and one IDLE cycle.
